// File: rtl/mc_ctrl.sv
// mc_ctrl: five-phase (IF/ID/EXE/MEM/WB) control sequencer for the MIPS-lite
// multi-cycle datapath. Decodes op/func into an instruction class, steps the
// FSM, handshakes with the instruction/data memories and counts retirements.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       RegDst,
  output logic             ALUSrc,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       ExtOp,
  output logic [1:0]       ALUOp,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_ADDU = 4'd1,
    C_SUBU = 4'd2,
    C_JR   = 4'd3,
    C_ORI  = 4'd4,
    C_LW   = 4'd5,
    C_SW   = 4'd6,
    C_BEQ  = 4'd7,
    C_LUI  = 4'd8,
    C_JAL  = 4'd9,
    C_J    = 4'd10
  } cls_t;

  state_t           state_r;
  state_t           next_s;
  cls_t             cls_s;
  logic [CNT_W-1:0] cnt_r;

  // raw (pre-reset-gating) strobes from the FSM
  logic imem_req_s;
  logic dmem_req_s;
  logic ir_we_s;
  logic pc_we_s;
  logic reg_write_s;
  logic mem_write_s;
  logic retire_s;

  // decoded mux selects
  logic [1:0] pc_sel_s;
  logic [1:0] reg_dst_s;
  logic       alu_src_s;
  logic [1:0] mem_to_reg_s;
  logic [1:0] ext_op_s;
  logic [1:0] alu_op_s;

  // Classify the current instruction; unsupported encodings become NOP.
  always_comb begin
    cls_s = C_NOP;
    case (op)
      6'b000000: begin
        case (func)
          6'b100001: cls_s = C_ADDU;
          6'b100011: cls_s = C_SUBU;
          6'b001000: cls_s = C_JR;
          default:   cls_s = C_NOP;
        endcase
      end
      6'b001101: cls_s = C_ORI;
      6'b100011: cls_s = C_LW;
      6'b101011: cls_s = C_SW;
      6'b000100: cls_s = C_BEQ;
      6'b001111: cls_s = C_LUI;
      6'b000011: cls_s = C_JAL;
      6'b000010: cls_s = C_J;
      default:   cls_s = C_NOP;
    endcase
  end

  // Datapath mux selects depend only on the instruction so they hold steady
  // across all of its phases.
  always_comb begin
    pc_sel_s     = 2'b00;
    reg_dst_s    = 2'b00;
    alu_src_s    = 1'b0;
    mem_to_reg_s = 2'b00;
    ext_op_s     = 2'b00;
    alu_op_s     = 2'b00;
    case (cls_s)
      C_ADDU: reg_dst_s = 2'b01;
      C_SUBU: begin
        reg_dst_s = 2'b01;
        alu_op_s  = 2'b01;
      end
      C_JR: begin
        reg_dst_s = 2'b01;
        pc_sel_s  = 2'b11;
      end
      C_ORI: begin
        alu_src_s = 1'b1;
        ext_op_s  = 2'b01;
        alu_op_s  = 2'b10;
      end
      C_LUI: begin
        alu_src_s = 1'b1;
        ext_op_s  = 2'b10;
        alu_op_s  = 2'b10;
      end
      C_LW: begin
        alu_src_s    = 1'b1;
        mem_to_reg_s = 2'b01;
      end
      C_SW: alu_src_s = 1'b1;
      C_BEQ: begin
        pc_sel_s = 2'b01;
        alu_op_s = 2'b01;
      end
      C_JAL: begin
        pc_sel_s     = 2'b10;
        reg_dst_s    = 2'b10;
        mem_to_reg_s = 2'b10;
      end
      C_J: pc_sel_s = 2'b10;
      default: begin
        // Other R-type encodings still select rd as destination.
        if (op == 6'b000000) begin
          reg_dst_s = 2'b01;
        end else begin
          reg_dst_s = 2'b00;
        end
      end
    endcase
  end

  // Next-state and strobe generation for the five-phase sequencer.
  always_comb begin
    next_s      = state_r;
    imem_req_s  = 1'b0;
    dmem_req_s  = 1'b0;
    ir_we_s     = 1'b0;
    pc_we_s     = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    case (state_r)
      S_IF: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          ir_we_s = 1'b1;
          pc_we_s = 1'b1;
          next_s  = S_ID;
        end else begin
          next_s  = S_IF;
        end
      end
      S_ID: begin
        case (cls_s)
          C_JAL: begin
            reg_write_s = 1'b1;
            pc_we_s     = 1'b1;
            next_s      = S_IF;
          end
          C_J, C_JR: begin
            pc_we_s = 1'b1;
            next_s  = S_IF;
          end
          C_NOP:   next_s = S_IF;
          default: next_s = S_EXE;
        endcase
      end
      S_EXE: begin
        case (cls_s)
          C_BEQ: begin
            pc_we_s = zero;
            next_s  = S_IF;
          end
          C_LW, C_SW:                    next_s = S_MEM;
          C_ADDU, C_SUBU, C_ORI, C_LUI:  next_s = S_WB;
          default:                       next_s = S_IF;
        endcase
      end
      S_MEM: begin
        dmem_req_s  = 1'b1;
        mem_write_s = (cls_s == C_SW);
        if (dmem_ack) begin
          if (cls_s == C_LW) begin
            next_s = S_WB;
          end else begin
            next_s = S_IF;
          end
        end else begin
          next_s = S_MEM;
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        next_s      = S_IF;
      end
      default: next_s = S_IF;
    endcase
    // An instruction completes whenever we return to IF from another phase.
    retire_s = (state_r != S_IF) && (next_s == S_IF);
  end

  // State register; synchronous active-low reset returns to IF.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_s;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (retire) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Strobes are suppressed for the whole time reset is held low, which also
  // kills a store in flight during the reset cycle.
  assign imem_req = reset & imem_req_s;
  assign dmem_req = reset & dmem_req_s;
  assign ir_we    = reset & ir_we_s;
  assign pc_we    = reset & pc_we_s;
  assign RegWrite = reset & reg_write_s;
  assign MemWrite = reset & mem_write_s;
  assign retire   = reset & retire_s;

  // PC+4 is the only legal PC source while fetching.
  assign pc_src   = (state_r == S_IF) ? 2'b00 : pc_sel_s;
  assign RegDst   = reg_dst_s;
  assign ALUSrc   = alu_src_s;
  assign MemtoReg = mem_to_reg_s;
  assign ExtOp    = ext_op_s;
  assign ALUOp    = alu_op_s;

  assign state    = state_r;
  assign inst_cnt = cnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl: one table row per clock cycle
// with hand-computed outputs, plus hand-written reset sequences.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BAD = 6'h3F;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_0    = 6'h00;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        zero;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [1:0]  RegDst;
  logic        ALUSrc;
  logic [1:0]  MemtoReg;
  logic        RegWrite;
  logic        MemWrite;
  logic [1:0]  ExtOp;
  logic [1:0]  ALUOp;
  logic [2:0]  state;
  logic        retire;
  logic [31:0] inst_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        iack;
    logic        dack;
    logic [2:0]  st;
    logic        ireq;
    logic        dreq;
    logic        irwe;
    logic        pcwe;
    logic [1:0]  pcsrc;
    logic [1:0]  rdst;
    logic        asrc;
    logic [1:0]  m2r;
    logic        rw;
    logic        mw;
    logic [1:0]  ext;
    logic [1:0]  aop;
    logic        ret;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ExtOp(ExtOp), .ALUOp(ALUOp),
    .state(state), .retire(retire), .inst_cnt(inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic row(
    input logic [5:0] op_i, input logic [5:0] func_i, input logic zero_i,
    input logic iack_i, input logic dack_i, input logic [2:0] st_i,
    input logic ireq_i, input logic dreq_i, input logic irwe_i, input logic pcwe_i,
    input logic [1:0] pcsrc_i, input logic [1:0] rdst_i, input logic asrc_i,
    input logic [1:0] m2r_i, input logic rw_i, input logic mw_i,
    input logic [1:0] ext_i, input logic [1:0] aop_i, input logic ret_i,
    input logic [31:0] cnt_i);
    vec_t v;
    v.op = op_i; v.func = func_i; v.zero = zero_i; v.iack = iack_i; v.dack = dack_i;
    v.st = st_i; v.ireq = ireq_i; v.dreq = dreq_i; v.irwe = irwe_i; v.pcwe = pcwe_i;
    v.pcsrc = pcsrc_i; v.rdst = rdst_i; v.asrc = asrc_i; v.m2r = m2r_i; v.rw = rw_i;
    v.mw = mw_i; v.ext = ext_i; v.aop = aop_i; v.ret = ret_i; v.cnt = cnt_i;
    tbl.push_back(v);
  endtask

  logic [20:0] got_v;
  logic [20:0] exp_v;

  initial begin
    reset = 1'b0; op = F_0; func = F_0; zero = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0;

    // ---- table: op func z ia da | st ireq dreq irwe pcwe pcsrc rdst asrc m2r rw mw ext aop ret cnt
    // addu, zero-wait; stray dmem_ack in EXE must be ignored
    row(OP_R,F_ADDU,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b00,0, 0);
    row(OP_R,F_ADDU,0,1,0, 3'd1,0,0,0,0, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b00,0, 0);
    row(OP_R,F_ADDU,0,0,1, 3'd2,0,0,0,0, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b00,0, 0);
    row(OP_R,F_ADDU,0,0,0, 3'd4,0,0,0,0, 2'b00,2'b01,0,2'b00,1,0,2'b00,2'b00,1, 0);
    // subu, one imem wait cycle
    row(OP_R,F_SUBU,0,0,0, 3'd0,1,0,0,0, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b01,0, 1);
    row(OP_R,F_SUBU,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b01,0, 1);
    row(OP_R,F_SUBU,0,0,0, 3'd1,0,0,0,0, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b01,0, 1);
    row(OP_R,F_SUBU,0,0,0, 3'd2,0,0,0,0, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b01,0, 1);
    row(OP_R,F_SUBU,0,0,0, 3'd4,0,0,0,0, 2'b00,2'b01,0,2'b00,1,0,2'b00,2'b01,1, 1);
    // ori
    row(OP_ORI,F_0,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b00,1,2'b00,0,0,2'b01,2'b10,0, 2);
    row(OP_ORI,F_0,0,0,0, 3'd1,0,0,0,0, 2'b00,2'b00,1,2'b00,0,0,2'b01,2'b10,0, 2);
    row(OP_ORI,F_0,0,0,0, 3'd2,0,0,0,0, 2'b00,2'b00,1,2'b00,0,0,2'b01,2'b10,0, 2);
    row(OP_ORI,F_0,0,0,0, 3'd4,0,0,0,0, 2'b00,2'b00,1,2'b00,1,0,2'b01,2'b10,1, 2);
    // lui
    row(OP_LUI,F_0,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b00,1,2'b00,0,0,2'b10,2'b10,0, 3);
    row(OP_LUI,F_0,0,0,0, 3'd1,0,0,0,0, 2'b00,2'b00,1,2'b00,0,0,2'b10,2'b10,0, 3);
    row(OP_LUI,F_0,0,0,0, 3'd2,0,0,0,0, 2'b00,2'b00,1,2'b00,0,0,2'b10,2'b10,0, 3);
    row(OP_LUI,F_0,0,0,0, 3'd4,0,0,0,0, 2'b00,2'b00,1,2'b00,1,0,2'b10,2'b10,1, 3);
    // lw, dmem_ack delayed 3 cycles: 8 cycles total
    row(OP_LW,F_0,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b00,1,2'b01,0,0,2'b00,2'b00,0, 4);
    row(OP_LW,F_0,0,0,0, 3'd1,0,0,0,0, 2'b00,2'b00,1,2'b01,0,0,2'b00,2'b00,0, 4);
    row(OP_LW,F_0,0,0,0, 3'd2,0,0,0,0, 2'b00,2'b00,1,2'b01,0,0,2'b00,2'b00,0, 4);
    row(OP_LW,F_0,0,0,0, 3'd3,0,1,0,0, 2'b00,2'b00,1,2'b01,0,0,2'b00,2'b00,0, 4);
    row(OP_LW,F_0,0,0,0, 3'd3,0,1,0,0, 2'b00,2'b00,1,2'b01,0,0,2'b00,2'b00,0, 4);
    row(OP_LW,F_0,0,0,0, 3'd3,0,1,0,0, 2'b00,2'b00,1,2'b01,0,0,2'b00,2'b00,0, 4);
    row(OP_LW,F_0,0,0,1, 3'd3,0,1,0,0, 2'b00,2'b00,1,2'b01,0,0,2'b00,2'b00,0, 4);
    row(OP_LW,F_0,0,0,0, 3'd4,0,0,0,0, 2'b00,2'b00,1,2'b01,1,0,2'b00,2'b00,1, 4);
    // sw, zero-wait
    row(OP_SW,F_0,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b00,1,2'b00,0,0,2'b00,2'b00,0, 5);
    row(OP_SW,F_0,0,0,0, 3'd1,0,0,0,0, 2'b00,2'b00,1,2'b00,0,0,2'b00,2'b00,0, 5);
    row(OP_SW,F_0,0,0,0, 3'd2,0,0,0,0, 2'b00,2'b00,1,2'b00,0,0,2'b00,2'b00,0, 5);
    row(OP_SW,F_0,0,0,1, 3'd3,0,1,0,0, 2'b00,2'b00,1,2'b00,0,1,2'b00,2'b00,1, 5);
    // beq taken
    row(OP_BEQ,F_0,1,1,0, 3'd0,1,0,1,1, 2'b00,2'b00,0,2'b00,0,0,2'b00,2'b01,0, 6);
    row(OP_BEQ,F_0,1,0,0, 3'd1,0,0,0,0, 2'b01,2'b00,0,2'b00,0,0,2'b00,2'b01,0, 6);
    row(OP_BEQ,F_0,1,0,0, 3'd2,0,0,0,1, 2'b01,2'b00,0,2'b00,0,0,2'b00,2'b01,1, 6);
    // beq not taken
    row(OP_BEQ,F_0,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b00,0,2'b00,0,0,2'b00,2'b01,0, 7);
    row(OP_BEQ,F_0,0,0,0, 3'd1,0,0,0,0, 2'b01,2'b00,0,2'b00,0,0,2'b00,2'b01,0, 7);
    row(OP_BEQ,F_0,0,0,0, 3'd2,0,0,0,0, 2'b01,2'b00,0,2'b00,0,0,2'b00,2'b01,1, 7);
    // jal
    row(OP_JAL,F_0,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b10,0,2'b10,0,0,2'b00,2'b00,0, 8);
    row(OP_JAL,F_0,0,0,0, 3'd1,0,0,0,1, 2'b10,2'b10,0,2'b10,1,0,2'b00,2'b00,1, 8);
    // j
    row(OP_J,F_0,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b00,0,2'b00,0,0,2'b00,2'b00,0, 9);
    row(OP_J,F_0,0,0,0, 3'd1,0,0,0,1, 2'b10,2'b00,0,2'b00,0,0,2'b00,2'b00,1, 9);
    // jr
    row(OP_R,F_JR,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b00,0, 10);
    row(OP_R,F_JR,0,0,0, 3'd1,0,0,0,1, 2'b11,2'b01,0,2'b00,0,0,2'b00,2'b00,1, 10);
    // unknown opcode behaves as NOP
    row(OP_BAD,F_0,0,1,0, 3'd0,1,0,1,1, 2'b00,2'b00,0,2'b00,0,0,2'b00,2'b00,0, 11);
    row(OP_BAD,F_0,0,0,0, 3'd1,0,0,0,0, 2'b00,2'b00,0,2'b00,0,0,2'b00,2'b00,1, 11);
    // back in IF waiting for imem
    row(OP_R,F_ADDU,0,0,0, 3'd0,1,0,0,0, 2'b00,2'b01,0,2'b00,0,0,2'b00,2'b00,0, 12);

    // ---- reset held for 3 cycles with imem_ack high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset_state_%0d", i), {61'd0, state}, 64'd0);
      chk($sformatf("reset_strobes_%0d", i),
          {57'd0, imem_req, dmem_req, ir_we, pc_we, RegWrite, MemWrite, retire}, 64'd0);
    end
    chk("reset_cnt", {32'd0, inst_cnt}, 64'd0);

    // ---- apply the table, one row per cycle
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      op = tbl[i].op; func = tbl[i].func; zero = tbl[i].zero;
      imem_ack = tbl[i].iack; dmem_ack = tbl[i].dack;
      #1;
      got_v = {state, imem_req, dmem_req, ir_we, pc_we, pc_src, RegDst, ALUSrc,
               MemtoReg, RegWrite, MemWrite, ExtOp, ALUOp, retire};
      exp_v = {tbl[i].st, tbl[i].ireq, tbl[i].dreq, tbl[i].irwe, tbl[i].pcwe,
               tbl[i].pcsrc, tbl[i].rdst, tbl[i].asrc, tbl[i].m2r, tbl[i].rw,
               tbl[i].mw, tbl[i].ext, tbl[i].aop, tbl[i].ret};
      chk($sformatf("row%0d_outputs", i), {43'd0, got_v}, {43'd0, exp_v});
      chk($sformatf("row%0d_inst_cnt", i), {32'd0, inst_cnt}, {32'd0, tbl[i].cnt});
    end

    // ---- sw aborted by reset during MEM
    @(negedge clk); op = OP_SW; func = F_0; imem_ack = 1'b1; dmem_ack = 1'b0; #1;
    chk("abort_fetch_ir_we", {63'd0, ir_we}, 64'd1);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("abort_id_state", {61'd0, state}, 64'd1);
    @(negedge clk); #1;
    chk("abort_exe_state", {61'd0, state}, 64'd2);
    @(negedge clk); #1;
    chk("abort_mem_state", {61'd0, state}, 64'd3);
    chk("abort_mem_write_before", {62'd0, MemWrite, dmem_req}, 64'd3);
    @(negedge clk); reset = 1'b0; #1;
    chk("abort_mem_write_in_reset", {61'd0, MemWrite, dmem_req, RegWrite}, 64'd0);
    chk("abort_no_retire", {63'd0, retire}, 64'd0);
    chk("abort_cnt_unchanged", {32'd0, inst_cnt}, 64'd12);
    @(negedge clk); reset = 1'b1; #1;
    chk("abort_state_if", {61'd0, state}, 64'd0);
    chk("abort_cnt_cleared", {32'd0, inst_cnt}, 64'd0);
    chk("abort_imem_req", {63'd0, imem_req}, 64'd1);
    @(negedge clk); #1;
    chk("abort_no_regwrite", {62'd0, RegWrite, MemWrite}, 64'd0);
    chk("abort_still_if", {61'd0, state}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS-lite core. It replaces the single-cycle decoder with a five-state FSM (IF, ID, EXE, MEM, WB) that steps the shared datapath one phase per cycle and drives the datapath enable strobes and mux selects. It also performs a req/ack handshake with the instruction and data memories and counts retired instructions. It sits between the instruction register (which supplies `op`/`func`), the ALU `zero` flag, the memories and the datapath muxes.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- op  in  6  opcode from instruction register
- func  in  6  function field from instruction register
- zero  in  1  ALU zero flag (valid in EXE)
- imem_ack  in  1  instruction memory word ready
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
- RegDst  out  2  00 rt, 01 rd, 10 $31
- ALUSrc  out  1  0 rt, 1 extended immediate
- MemtoReg  out  2  00 ALU result, 01 memory data, 10 PC
- RegWrite  out  1  register file write strobe
- MemWrite  out  1  data memory write strobe
- ExtOp  out  2  00 sign, 01 zero, 10 upper (lui)
- ALUOp  out  2  00 add, 01 sub, 10 or
- state  out  3  IF=0, ID=1, EXE=2, MEM=3, WB=4
- retire  out  1  one-cycle pulse on instruction completion
- inst_cnt  out  CNT_W  retired-instruction count

## Operation
- Decoded classes: addu (op 000000 func 100001), subu (000000/100011), jr (000000/001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, jal 000011, j 000010. Anything else, including other R-type funcs, is a NOP.
- IF: imem_req=1. Stays in IF until imem_ack. In the ack cycle: ir_we=1, pc_we=1, pc_src=00, next=ID.
- ID: jal → RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4), pc_we=1, pc_src=10, next=IF. j → pc_we, pc_src=10, next=IF. jr → pc_we, pc_src=11, next=IF. NOP → next=IF. All other classes → EXE.
- EXE: beq → ALUOp=01, ALUSrc=0; if zero then pc_we=1, pc_src=01; next=IF. lw/sw → ALUOp=00, ALUSrc=1, ExtOp=00, next=MEM. addu/subu → ALUOp 00/01, ALUSrc=0, next=WB. ori → ALUOp=10, ExtOp=01, ALUSrc=1, next=WB. lui → ALUOp=10, ExtOp=10, ALUSrc=1 (rs treated as $0 by datapath), next=WB.
- MEM: dmem_req=1. For sw, MemWrite=1 is also held. Stays in MEM until dmem_ack. On ack: lw → WB, sw → IF.
- WB: RegWrite=1 for exactly one cycle. RegDst=01 for R-type, 00 otherwise. MemtoReg=01 for lw, 00 otherwise. next=IF.
- Mux selects are combinational from op/func and remain stable for the whole instruction. Strobes (ir_we, pc_we, RegWrite, MemWrite, imem_req, dmem_req) are asserted only in the states listed above.
- retire pulses on every transition into IF other than from reset. inst_cnt increments on retire and wraps modulo 2^CNT_W.

## Timing
- Reset (reset=0 at a rising edge): state=IF, inst_cnt=0. While reset is low, all strobes and retire are forced to 0. On the first cycle after release, imem_req=1.
- Zero-wait latencies with ack in the same cycle as req: jal/j/jr/NOP 2 cycles, beq 3, addu/subu/ori/lui/sw 4, lw 5. Each memory wait cycle adds 1.
- An ack in the same cycle as its req is accepted. An ack while no request is pending is ignored.
- pc_we and ir_we are each asserted for exactly one cycle per fetch, regardless of how many wait cycles precede the ack.
- Reset mid-MEM aborts the access. MemWrite is low from the reset cycle onward, and no RegWrite follows.
- retire and the inst_cnt update occur in the cycle whose next state is IF. inst_cnt is visible one cycle later.

## Test plan
- Reset held 3 cycles, then released with imem_ack tied high → state=0, strobes 0 during reset; imem_req=1 in the first cycle after release; inst_cnt=0.
- addu (op 0, func 0x21), zero-wait → states 0,1,2,4,0; RegWrite high only in WB with RegDst=01; retire once; inst_cnt=1.
- lw with dmem_ack delayed 3 cycles → MEM held 4 cycles with dmem_req=1; WB then asserts MemtoReg=01, RegWrite=1; total 8 cycles.
- beq with zero=1, then zero=0 → pc_we in EXE with pc_src=01 only for the first; both complete in 3 cycles.
- jal → ID asserts RegWrite, RegDst=10, MemtoReg=10, pc_we, pc_src=10; back in IF after 2 cycles.
- sw with reset dropped during MEM → MemWrite low in the reset cycle; state=IF after reset; inst_cnt unchanged by the aborted sw, then cleared to 0 by the reset.
